// File: rtl/pc_unit_rs_if.sv
// pc_unit_rs_if: control-side bundle for pc_unit_rs.
// Carries the op select and target in, and the PC and stack status out.
interface pc_unit_rs_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);
    logic             en;
    logic [2:0]       ps;
    logic [WIDTH-1:0] pc_in;
    logic             err_clr;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] ret_top;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
    modport master (
        output en, ps, pc_in, err_clr,
        input  pc_out, ret_top, depth, full, empty, ovf, unf
    );
    modport slave (
        input  en, ps, pc_in, err_clr,
        output pc_out, ret_top, depth, full, empty, ovf, unf
    );
endinterface

// File: rtl/pc_unit_rs.sv
// pc_unit_rs: program counter with hardware return-address stack and sticky ovf/unf flags.
// Define PC_STACK_TRAP_EN to redirect a failed push or pop to TRAP_VECTOR.
module pc_unit_rs #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 8,
    parameter int               STEP        = 1,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = '0
) (
    input logic         clock,
    input logic         reset,
    pc_unit_rs_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [DW-1:0]    r_depth;
    logic             r_ovf, r_unf;
    logic             w_full, w_empty, w_push, w_pop, w_ovf, w_unf, w_do_push, w_do_pop, w_jump;
    logic [WIDTH-1:0] w_seq, w_rel, w_top, w_pc_next;
    always_comb begin
        w_full    = r_depth == DW'(DEPTH);
        w_empty   = r_depth == '0;
        w_seq     = r_pc + WIDTH'(STEP);
        w_rel     = r_pc + bus.pc_in;
        w_top     = w_empty ? '0 : r_stack[AW'(r_depth - 1'b1)];
        w_push    = bus.ps == 3'b100 || bus.ps == 3'b101;
        w_pop     = bus.ps == 3'b110;
        w_jump    = w_push || bus.ps == 3'b010 || bus.ps == 3'b011;
        w_ovf     = w_push && w_full;
        w_unf     = w_pop && w_empty;
        w_do_push = bus.en && w_push && !w_full;
        w_do_pop  = bus.en && w_pop && !w_empty;
        // ps[0] picks relative over absolute for every jump/call encoding
        w_pc_next = bus.ps == 3'b001 ? w_seq :
                    w_jump ? (bus.ps[0] ? w_rel : bus.pc_in) :
                    (w_pop && !w_empty) ? w_top : r_pc;
`ifdef PC_STACK_TRAP_EN
        if (w_ovf || w_unf) w_pc_next = TRAP_VECTOR;
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (bus.en) r_pc <= w_pc_next;
            r_depth <= r_depth + DW'(w_do_push) - DW'(w_do_pop);
            r_ovf   <= (bus.en && w_ovf) || (r_ovf && !bus.err_clr);
            r_unf   <= (bus.en && w_unf) || (r_unf && !bus.err_clr);
        end
    end
    always_ff @(posedge clock) begin
        if (w_do_push) r_stack[AW'(r_depth)] <= w_seq;
    end
    assign bus.pc_out  = r_pc;
    assign bus.ret_top = w_top;
    assign bus.depth   = r_depth;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
endmodule

// File: tb/tb_pc_unit_rs.sv
// tb_pc_unit_rs: directed vectors for pc_unit_rs, WIDTH=32 DEPTH=8 STEP=1 RESET_PC=0 TRAP_VECTOR=4.
// Expected PCs after failed push/pop follow PC_STACK_TRAP_EN when it is defined.
module tb_pc_unit_rs;
`ifdef PC_STACK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    pc_unit_rs_if #(.WIDTH(32), .DEPTH(8)) bus ();
    pc_unit_rs #(.WIDTH(32), .DEPTH(8), .STEP(1), .RESET_PC(32'h0), .TRAP_VECTOR(32'h4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic [2:0] ps, input logic [31:0] pc_in,
                        input logic en = 1'b1, input logic clr = 1'b0);
        bus.ps      = ps;
        bus.pc_in   = pc_in;
        bus.en      = en;
        bus.err_clr = clr;
        @(posedge clock);
        #1;
    endtask
    initial begin
        bus.en = 1'b0;
        bus.ps = 3'b000;
        bus.pc_in = '0;
        bus.err_clr = 1'b0;
        #1;
        check("rst_pc", bus.pc_out, 32'h0);
        check("rst_depth", 32'(bus.depth), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_unf", 32'(bus.unf), 32'd0);
        check("rst_top", bus.ret_top, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(3'b001, 32'h0);
            check("inc_pc", bus.pc_out, 32'(i));
        end
        check("inc_depth", 32'(bus.depth), 32'd0);
        check("inc_empty", 32'(bus.empty), 32'd1);
        step(3'b010, 32'h10);
        check("abs_pc", bus.pc_out, 32'h10);
        step(3'b100, 32'h200);
        check("call_pc", bus.pc_out, 32'h200);
        check("call_top", bus.ret_top, 32'h11);
        check("call_depth", 32'(bus.depth), 32'd1);
        check("call_empty", 32'(bus.empty), 32'd0);
        step(3'b110, 32'h0);
        check("ret_pc", bus.pc_out, 32'h11);
        check("ret_depth", 32'(bus.depth), 32'd0);
        check("ret_empty", 32'(bus.empty), 32'd1);
        check("ret_top0", bus.ret_top, 32'h0);
        step(3'b010, 32'h40);
        step(3'b101, 32'hFFFF_FFF0);
        check("callrel_pc", bus.pc_out, 32'h30);
        check("callrel_top", bus.ret_top, 32'h41);
        step(3'b110, 32'h0);
        check("callrel_ret", bus.pc_out, 32'h41);
        step(3'b011, 32'h5);
        check("rel_pc", bus.pc_out, 32'h46);
        step(3'b010, 32'hFFFF_FFFF);
        step(3'b001, 32'h0);
        check("wrap_pc", bus.pc_out, 32'h0);
        check("wrap_ovf", 32'(bus.ovf), 32'd0);
        check("wrap_unf", 32'(bus.unf), 32'd0);
        step(3'b111, 32'h123);
        check("rsvd_pc", bus.pc_out, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(3'b100, 32'(32'h100 + i * 16));
            check("fill_pc", bus.pc_out, 32'(32'h100 + i * 16));
            check("fill_depth", 32'(bus.depth), 32'(i + 1));
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_top", bus.ret_top, 32'h161);
        step(3'b100, 32'h180);
        check("ovf_pc", bus.pc_out, TRAP ? 32'h4 : 32'h180);
        check("ovf_depth", 32'(bus.depth), 32'd8);
        check("ovf_flag", 32'(bus.ovf), 32'd1);
        check("ovf_top", bus.ret_top, 32'h161);
        step(3'b000, 32'h0, 1'b1, 1'b1);
        check("ovf_clr", 32'(bus.ovf), 32'd0);
        step(3'b100, 32'h190, 1'b1, 1'b1);
        check("ovf_setwins", 32'(bus.ovf), 32'd1);
        step(3'b000, 32'h0, 1'b1, 1'b1);
        check("ovf_clr2", 32'(bus.ovf), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(3'b110, 32'h0);
            check("drain_pc", bus.pc_out, k < 7 ? 32'(32'h101 + (6 - k) * 16) : 32'h1);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        step(3'b010, 32'h80);
        step(3'b110, 32'h0);
        check("unf_pc", bus.pc_out, TRAP ? 32'h4 : 32'h80);
        check("unf_flag", 32'(bus.unf), 32'd1);
        check("unf_depth", 32'(bus.depth), 32'd0);
        check("unf_ovf", 32'(bus.ovf), 32'd0);
        step(3'b001, 32'h0, 1'b0, 1'b1);
        check("stall_clr_unf", 32'(bus.unf), 32'd0);
        check("stall_clr_pc", bus.pc_out, TRAP ? 32'h4 : 32'h80);
        step(3'b010, 32'h80);
        step(3'b100, 32'h300);
        check("pre_stall_pc", bus.pc_out, 32'h300);
        step(3'b100, 32'h500, 1'b0);
        check("stall_pc", bus.pc_out, 32'h300);
        check("stall_depth", 32'(bus.depth), 32'd1);
        check("stall_top", bus.ret_top, 32'h81);
        step(3'b110, 32'h0);
        check("pop1_pc", bus.pc_out, 32'h81);
        step(3'b110, 32'h0);
        check("pop2_unf", 32'(bus.unf), 32'd1);
        check("pop2_pc", bus.pc_out, TRAP ? 32'h4 : 32'h81);
        step(3'b100, 32'h600);
        check("prereset_depth", 32'(bus.depth), 32'd1);
        bus.en = 1'b0;
        bus.ps = 3'b100;
        bus.pc_in = 32'h500;
        #2 reset = 1'b1;
        #1;
        check("areset_pc", bus.pc_out, 32'h0);
        check("areset_depth", 32'(bus.depth), 32'd0);
        check("areset_unf", 32'(bus.unf), 32'd0);
        check("areset_ovf", 32'(bus.ovf), 32'd0);
        check("areset_empty", 32'(bus.empty), 32'd1);
        check("areset_top", bus.ret_top, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        step(3'b100, 32'h500, 1'b0);
        check("post_reset_pc", bus.pc_out, 32'h0);
        check("post_reset_depth", 32'(bus.depth), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
